// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO responder: FSM encoding, frame field codes
// and the rising-event indices at which the frame decoder takes decisions.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_TA   = 3'd2,
        S_DATA = 3'd3,
        S_SKIP = 3'd4,
        S_WAIT = 3'd5
    } state_t;

    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA_WR   = 2'b10;

    // Rising-event numbers (1-based) where the decoder acts
    localparam logic [5:0] EV_OP   = 6'd4;
    localparam logic [5:0] EV_ADDR = 6'd14;
    localparam logic [5:0] EV_TA   = 6'd16;
    localparam logic [5:0] EV_END  = 6'd32;

    // Read-only identifier register addresses
    localparam logic [4:0] REG_ID1 = 5'd2;
    localparam logic [4:0] REG_ID2 = 5'd3;

endpackage

// File: rtl/mdio_regfile.sv
// 32x16 management register space. One write port, one combinational read
// port; addresses 2 and 3 return fixed identifier words and ignore writes.
module mdio_regfile
    import mdio_pkg::*;
#(
    parameter logic [15:0] PHY_ID1 = 16'h0141,
    parameter logic [15:0] PHY_ID2 = 16'h0CC2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [4:0]  i_raddr,
    output logic [15:0] o_rdata
);

    logic [15:0] r_mem [0:31];

    // Storage: cleared by reset, written when the decoder commits a frame
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (i_we && (i_waddr != REG_ID1) && (i_waddr != REG_ID2)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr == REG_ID1) ? PHY_ID1 :
                     (i_raddr == REG_ID2) ? PHY_ID2 :
                     r_mem[i_raddr];

endmodule

// File: rtl/mdio_responder.sv
// PHY-side MDIO target: follows the controller's mdc in the clk domain,
// decodes 32-bit preamble-less frames, commits writes to the local register
// file and serialises read data back on mdio_in.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'h15,
    parameter logic [15:0] PHY_ID1  = 16'h0141,
    parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_out,
    input  logic        mdio_oe,
    output logic        mdio_in,
    output logic        mdio_in_oe,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        busy
);

    state_t      r_state;
    logic        r_mdc_q;
    logic [5:0]  r_cnt;
    logic [8:0]  r_hdr;
    logic [1:0]  r_op;
    logic [4:0]  r_regad;
    logic [1:0]  r_ta;
    logic [14:0] r_wdata_sh;
    logic [15:0] r_rd_sh;
    logic        r_in;
    logic        r_in_oe;
    logic        r_stb;
    logic [4:0]  r_waddr;
    logic [15:0] r_wdata;

    logic        w_rise;
    logic        w_fall;
    logic [5:0]  w_cnt_nx;
    logic [9:0]  w_hdr_nx;
    logic [15:0] w_data_nx;
    logic [15:0] w_rd_word;
    logic        w_commit;

    assign w_rise    = mdc & ~r_mdc_q;
    assign w_fall    = ~mdc & r_mdc_q;
    // Event counter saturates so SKIP/DATA can never wrap into a new frame
    assign w_cnt_nx  = (r_cnt == EV_END) ? EV_END : r_cnt + 6'd1;
    // Header / data bits including the one sampled on this rising event
    assign w_hdr_nx  = {r_hdr, mdio_out};
    assign w_data_nx = {r_wdata_sh, mdio_out};
    assign w_commit  = w_rise && (r_state == S_DATA) && (w_cnt_nx == EV_END) &&
                       (r_op == OP_WR) && (r_ta == TA_WR) &&
                       (r_regad != REG_ID1) && (r_regad != REG_ID2);

    mdio_regfile #(
        .PHY_ID1 (PHY_ID1),
        .PHY_ID2 (PHY_ID2)
    ) u_regfile (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (w_commit),
        .i_waddr (r_regad),
        .i_wdata (w_data_nx),
        .i_raddr (w_hdr_nx[4:0]),
        .o_rdata (w_rd_word)
    );

    // mdc history for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mdc_q <= 1'b0;
        end else begin
            r_mdc_q <= mdc;
        end
    end

    // Frame decoder FSM with registered drive and write-report outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_hdr      <= 9'd0;
            r_op       <= 2'b00;
            r_regad    <= 5'd0;
            r_ta       <= 2'b00;
            r_wdata_sh <= 15'd0;
            r_rd_sh    <= 16'h0000;
            r_in       <= 1'b0;
            r_in_oe    <= 1'b0;
            r_stb      <= 1'b0;
            r_waddr    <= 5'd0;
            r_wdata    <= 16'h0000;
        end else begin
            r_stb <= 1'b0;
            if (w_commit) begin
                r_stb   <= 1'b1;
                r_waddr <= r_regad;
                r_wdata <= w_data_nx;
            end

            // Read drive: turnaround zero, 16 data bits, then release
            if (w_fall) begin
                if ((r_state == S_TA) && (r_cnt == EV_TA - 6'd1) && (r_op == OP_RD)) begin
                    r_in_oe <= 1'b1;
                    r_in    <= 1'b0;
                end else if ((r_state == S_DATA) && r_in_oe) begin
                    r_in    <= r_rd_sh[15];
                    r_rd_sh <= {r_rd_sh[14:0], 1'b0};
                end else if (r_state == S_IDLE) begin
                    r_in_oe <= 1'b0;
                    r_in    <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rise && mdio_oe) begin
                        r_state <= S_HDR;
                        r_cnt   <= 6'd1;
                        r_hdr   <= {8'd0, mdio_out};
                    end
                end
                S_HDR: begin
                    if (w_rise) begin
                        r_cnt <= w_cnt_nx;
                        r_hdr <= w_hdr_nx[8:0];
                        if (w_cnt_nx == EV_OP) begin
                            r_op <= w_hdr_nx[1:0];
                            if ((w_hdr_nx[3:2] != ST_CODE) ||
                                ((w_hdr_nx[1:0] != OP_WR) && (w_hdr_nx[1:0] != OP_RD))) begin
                                r_state <= S_WAIT;
                            end
                        end else if (w_cnt_nx == EV_ADDR) begin
                            r_regad <= w_hdr_nx[4:0];
                            if (w_hdr_nx[9:5] != PHY_ADDR) begin
                                r_state <= S_SKIP;
                            end else begin
                                r_state <= S_TA;
                                // Snapshot of the addressed word for the read
                                if (r_op == OP_RD) begin
                                    r_rd_sh <= w_rd_word;
                                end
                            end
                        end
                    end
                end
                S_TA: begin
                    if (w_rise) begin
                        r_cnt <= w_cnt_nx;
                        r_ta  <= {r_ta[0], mdio_out};
                        if (w_cnt_nx == EV_TA) begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rise) begin
                        r_cnt      <= w_cnt_nx;
                        r_wdata_sh <= w_data_nx[14:0];
                        if (w_cnt_nx == EV_END) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_SKIP: begin
                    if (w_rise) begin
                        r_cnt <= w_cnt_nx;
                        if (w_cnt_nx == EV_END) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    if (!mdio_oe) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mdio_in    = r_in;
    assign mdio_in_oe = r_in_oe;
    assign wr_stb     = r_stb;
    assign wr_addr    = r_waddr;
    assign wr_data    = r_wdata;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: directed and randomized frames driven on mdc /
// mdio_out, compared against a frame-level register-space model.
module tb_mdio_responder;

    localparam logic [4:0]  PHY   = 5'h15;
    localparam logic [15:0] ID1   = 16'h0141;
    localparam logic [15:0] ID2   = 16'h0CC2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oe;
    logic        mdio_in;
    logic        mdio_in_oe;
    logic        wr_stb;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int stb_cnt = 0;

    logic [15:0] m_regs [32];

    mdio_responder #(
        .PHY_ADDR (PHY),
        .PHY_ID1  (ID1),
        .PHY_ID2  (ID2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mdc        (mdc),
        .mdio_out   (mdio_out),
        .mdio_oe    (mdio_oe),
        .mdio_in    (mdio_in),
        .mdio_in_oe (mdio_in_oe),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Count clk cycles with the write strobe high, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_stb) stb_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                       input logic [4:0] phy, input logic [4:0] ra,
                                       input logic [1:0] ta, input logic [15:0] d);
        return {st, op, phy, ra, ta, d};
    endfunction

    function automatic logic [15:0] m_read(input logic [4:0] ra);
        if (ra == 5'd2) return ID1;
        if (ra == 5'd3) return ID2;
        return m_regs[ra];
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        mdc      = 1'b0;
        mdio_oe  = 1'b0;
        mdio_out = 1'b0;
        #1;
        chk({tag, "_in"},    {31'd0, mdio_in},    32'd0);
        chk({tag, "_oe"},    {31'd0, mdio_in_oe}, 32'd0);
        chk({tag, "_stb"},   {31'd0, wr_stb},     32'd0);
        chk({tag, "_busy"},  {31'd0, busy},       32'd0);
        clk_wait(2);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
        clk_wait(1);
    endtask

    // Drive one frame; abort_at>0 asserts reset during that rising event's high phase
    task automatic run_frame(input logic [31:0] w, input int abort_at);
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [1:0]  ta;
        logic [15:0] d;
        logic [15:0] rdval;
        logic        hdr_ok, mine, is_rd, commit, exp_oe, exp_in;
        int          stb0, l, h;
        st = w[31:30]; op = w[29:28]; phy = w[27:23]; ra = w[22:18]; ta = w[17:16]; d = w[15:0];
        hdr_ok = (st == 2'b01) && (op == 2'b01 || op == 2'b10);
        mine   = hdr_ok && (phy == PHY);
        is_rd  = mine && (op == 2'b10);
        commit = mine && (op == 2'b01) && (ta == 2'b10) && (ra != 5'd2) && (ra != 5'd3);
        rdval  = m_read(ra);
        stb0   = stb_cnt;
        for (int k = 1; k <= 32; k++) begin
            mdc = 1'b0; mdio_out = w[32-k]; mdio_oe = 1'b1;
            l = $urandom_range(1, 3);
            h = $urandom_range(1, 3);
            clk_wait(l);
            if (k >= 2) begin
                exp_oe = is_rd && (k >= 16);
                exp_in = 1'b0;
                if (is_rd && k >= 17) exp_in = rdval[32-k];
                chk($sformatf("drv_oe_k%0d", k), {31'd0, mdio_in_oe}, {31'd0, exp_oe});
                chk($sformatf("drv_in_k%0d", k), {31'd0, mdio_in},    {31'd0, exp_in});
            end
            mdc = 1'b1;
            clk_wait(1);
            if (k == 1) chk("busy_start", {31'd0, busy}, 32'd1);
            if (k == abort_at) begin
                do_reset("abort");
                return;
            end
            if (k == 32) begin
                chk("wr_stb_pulse", {31'd0, wr_stb}, {31'd0, commit});
                if (commit) begin
                    chk("wr_addr", {27'd0, wr_addr}, {27'd0, ra});
                    chk("wr_data", {16'd0, wr_data}, {16'd0, d});
                    m_regs[ra] = d;
                end
                clk_wait(1);
                chk("wr_stb_end", {31'd0, wr_stb}, 32'd0);
            end
            if (h > 1) clk_wait(h - 1);
        end
        mdc = 1'b0;
        clk_wait(2);
        chk("rel_oe", {31'd0, mdio_in_oe}, 32'd0);
        chk("rel_in", {31'd0, mdio_in},    32'd0);
        chk("busy_end", {31'd0, busy}, {31'd0, !hdr_ok});
        chk("stb_count", stb_cnt - stb0, {31'd0, commit});
        mdio_oe = 1'b0;
        clk_wait(2);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [1:0]  st, op, ta;
        logic [4:0]  phy, ra;
        int          sel;
        reset = 1'b1; mdc = 1'b0; mdio_out = 1'b0; mdio_oe = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
        // mdc activity under reset must not start anything
        for (int i = 0; i < 4; i++) begin
            mdc = ~mdc;
            clk_wait(2);
        end
        chk("rst_in",   {31'd0, mdio_in},    32'd0);
        chk("rst_oe",   {31'd0, mdio_in_oe}, 32'd0);
        chk("rst_stb",  {31'd0, wr_stb},     32'd0);
        chk("rst_busy", {31'd0, busy},       32'd0);
        mdc = 1'b0; mdio_oe = 1'b0;
        clk_wait(2);
        reset = 1'b0;
        clk_wait(2);

        run_frame(mk(2'b01, 2'b10, PHY, 5'd5, 2'b00, 16'h0000), 0);
        run_frame(32'h55555555, 0);
        run_frame(mk(2'b01, 2'b10, 5'h15, 5'h0A, 2'b11, 16'hFFFF), 0);
        run_frame(32'h65557777, 0);
        run_frame(32'h15555555, 0);
        run_frame(mk(2'b01, 2'b10, PHY, 5'd2, 2'b00, 16'h0000), 0);
        run_frame(mk(2'b01, 2'b10, PHY, 5'd3, 2'b00, 16'h0000), 0);
        run_frame(mk(2'b01, 2'b01, PHY, 5'd2, 2'b10, 16'hDEAD), 0);
        run_frame(mk(2'b01, 2'b01, PHY, 5'd7, 2'b00, 16'h1234), 0);
        run_frame(mk(2'b01, 2'b10, PHY, 5'd2, 2'b00, 16'h0000), 0);
        run_frame(mk(2'b01, 2'b10, PHY, 5'h0A, 2'b00, 16'h0000), 20);
        run_frame(mk(2'b01, 2'b01, PHY, 5'h1F, 2'b10, 16'hBEEF), 0);
        run_frame(mk(2'b01, 2'b10, PHY, 5'h1F, 2'b00, 16'h0000), 0);
        run_frame(mk(2'b01, 2'b10, PHY, 5'h0A, 2'b00, 16'h0000), 0);

        for (int n = 0; n < 50; n++) begin
            sel = $urandom_range(0, 9);
            st  = 2'b01;
            phy = PHY;
            ra  = 5'($urandom);
            ta  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
            if (sel == 0) begin
                st = 2'($urandom);
                op = (st == 2'b01) ? (($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11) : 2'($urandom);
            end else if (sel <= 4) begin
                op = 2'b01;
            end else begin
                op = 2'b10;
                if (sel == 9) phy = 5'($urandom);
            end
            run_frame(mk(st, op, phy, ra, ta, 16'($urandom)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
